// File: rtl/sseg_display_arbiter.sv
// sseg_display_arbiter: round-robin owner of the shared 4-digit display, with a minimum dwell per owner
// and a blanked gap between owners; all outputs registered.
module sseg_display_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int BLANK_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [14*N_REQ-1:0]   req_num,
    input  logic [4*N_REQ-1:0]    req_dig_en,
    input  logic [4*N_REQ-1:0]    req_dp_en,
    output logic [N_REQ-1:0]      gnt,
    output logic [2:0]            owner,
    output logic                  busy,
    output logic                  ovf,
    output logic [13:0]           num,
    output logic [3:0]            dig_en,
    output logic [3:0]            dp_en
);
    localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    state_t state, state_nx;
    logic [2:0] ptr, ptr_nx, owner_nx, pick;
    logic [DW-1:0] dwell_cnt, dwell_nx;
    logic [BW-1:0] blank_cnt, blank_nx;
    logic [2*N_REQ-1:0] rot;
    logic [N_REQ-1:0] own_mask, nx_mask;
    logic [13:0] sel_num;
    logic any_req, own_req, other_req, dwell_last, blank_last;
    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        rot = {req, req} >> ptr;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) pick = 3'((int'(ptr) + k) % N_REQ);
    end
    assign own_mask   = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    assign nx_mask    = {{(N_REQ-1){1'b0}}, 1'b1} << owner_nx;
    assign any_req    = |req;
    assign own_req    = |(req & own_mask);
    assign other_req  = |(req & ~own_mask);
    assign dwell_last = dwell_cnt == DW'(DWELL_CYCLES - 1);
    assign blank_last = blank_cnt == BW'(BLANK_CYCLES - 1);
    assign sel_num    = 14'(req_num >> (14 * owner_nx));
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        dwell_nx = dwell_cnt;
        blank_nx = blank_cnt;
        case (state)
            IDLE: if (any_req) begin
                state_nx = SHOW;
                owner_nx = pick;
                dwell_nx = '0;
            end
            SHOW: if (!own_req || (dwell_last && other_req)) begin
                state_nx = BLANK;
                blank_nx = '0;
                ptr_nx   = (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;
            end else begin
                dwell_nx = dwell_last ? '0 : dwell_cnt + 1'b1;
            end
            BLANK: if (blank_last) begin
                state_nx = any_req ? SHOW : IDLE;
                owner_nx = any_req ? pick : owner;
                dwell_nx = '0;
            end else begin
                blank_nx = blank_cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            num       <= '0;
            dig_en    <= '0;
            dp_en     <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            dwell_cnt <= dwell_nx;
            blank_cnt <= blank_nx;
            gnt       <= state_nx == SHOW ? nx_mask : '0;
            busy      <= state_nx != IDLE;
            ovf       <= state_nx == SHOW && sel_num > 14'd9999;
            dig_en    <= state_nx == SHOW ? 4'(req_dig_en >> (4 * owner_nx)) : 4'd0;
            dp_en     <= state_nx == SHOW ? 4'(req_dp_en >> (4 * owner_nx)) : 4'd0;
            if (state_nx == SHOW) num <= sel_num > 14'd9999 ? 14'd9999 : sel_num;
        end
    end
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// tb_sseg_display_arbiter: directed and random stimulus; a reference model queues expected
// outputs per cycle and a monitor compares them against the DUT one cycle later.
module tb_sseg_display_arbiter;
    localparam int N = 4, D = 8, B = 2;
    localparam int M_IDLE = 0, M_SHOW = 1, M_BLANK = 2;
    typedef struct packed {
        logic [3:0]  gnt;
        logic [2:0]  owner;
        logic        busy;
        logic        ovf;
        logic [13:0] num;
        logic [3:0]  dig;
        logic [3:0]  dp;
    } exp_t;
    logic clk = 0, rst_n = 0;
    logic [N-1:0] req = '0;
    logic [14*N-1:0] req_num = '0;
    logic [4*N-1:0] req_dig_en = '0, req_dp_en = '0;
    logic [N-1:0] gnt;
    logic [2:0] owner;
    logic busy, ovf;
    logic [13:0] num;
    logic [3:0] dig_en, dp_en;
    logic [N-1:0] nx_req = '0;
    logic [14*N-1:0] nx_num = '0;
    logic [4*N-1:0] nx_dig = '0, nx_dp = '0;
    int n_chk = 0, n_fail = 0;
    int m_mode, m_owner, m_ptr, m_shown, m_gap;
    logic [13:0] m_num;
    exp_t q[$];

    sseg_display_arbiter #(.N_REQ(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_num(req_num), .req_dig_en(req_dig_en),
        .req_dp_en(req_dp_en), .gnt(gnt), .owner(owner), .busy(busy), .ovf(ovf),
        .num(num), .dig_en(dig_en), .dp_en(dp_en));

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.gnt = gnt; a.owner = owner; a.busy = busy; a.ovf = ovf;
        a.num = num; a.dig = dig_en; a.dp = dp_en;
        return a;
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got gnt=%b own=%0d busy=%b ovf=%b num=%0d dig=%h dp=%h expected gnt=%b own=%0d busy=%b ovf=%b num=%0d dig=%h dp=%h",
                     name, $time, a.gnt, a.owner, a.busy, a.ovf, a.num, a.dig, a.dp,
                     e.gnt, e.owner, e.busy, e.ovf, e.num, e.dig, e.dp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_owner = 0; m_ptr = 0; m_shown = 0; m_gap = 0; m_num = '0;
    endtask

    // First requester at or after the round-robin pointer, wrapping around.
    function automatic int pick_owner();
        for (int k = 0; k < N; k++)
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return 0;
    endfunction

    task automatic model_step();
        exp_t e;
        int v;
        bit others;
        others = (req & ~(4'b1 << m_owner)) != 0;
        if (m_mode == M_IDLE) begin
            if (req != 0) begin m_owner = pick_owner(); m_mode = M_SHOW; m_shown = 0; end
        end else if (m_mode == M_SHOW) begin
            if (!req[m_owner] || (m_shown == D - 1 && others)) begin
                m_mode = M_BLANK; m_gap = 0; m_ptr = (m_owner + 1) % N;
            end else m_shown = (m_shown + 1) % D;
        end else begin
            if (m_gap == B - 1) begin
                if (req != 0) begin m_owner = pick_owner(); m_mode = M_SHOW; m_shown = 0; end
                else m_mode = M_IDLE;
            end else m_gap++;
        end
        e.owner = 3'(m_owner);
        e.busy  = m_mode != M_IDLE;
        e.gnt   = m_mode == M_SHOW ? 4'(1 << m_owner) : 4'd0;
        if (m_mode == M_SHOW) begin
            v = int'(req_num[14*m_owner +: 14]);
            e.ovf = v > 9999;
            m_num = 14'(v > 9999 ? 9999 : v);
            e.dig = req_dig_en[4*m_owner +: 4];
            e.dp  = req_dp_en[4*m_owner +: 4];
        end else begin
            e.ovf = 0; e.dig = 0; e.dp = 0;
        end
        e.num = m_num;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            req = nx_req; req_num = nx_num; req_dig_en = nx_dig; req_dp_en = nx_dp;
            model_step();
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #3 rst_n = 0;
        #1 check(name, actual(), '0);
        model_reset();
        nx_req = '0;
        tick(2);
        q.delete();
        @(negedge clk) rst_n = 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            check("cycle", actual(), q.pop_front());
            n_chk++;
            if (!$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL gnt_onehot0 t=%0t got gnt=%b expected at most one bit set", $time, gnt);
            end
        end
    end

    initial begin
        model_reset();
        #17 check("reset_state", actual(), '0);
        rst_n = 1;
        nx_num[13:0] = 14'd2468; nx_dig[3:0] = 4'hF; nx_req = 4'b0001;
        tick(30);
        nx_num[13:0] = 14'd1111; nx_num[41:28] = 14'd2222; nx_dig = 16'hFFFF; nx_dp = 16'h0102;
        nx_req = 4'b0101;
        tick(45);
        do_reset("reset_mid_show_a");
        nx_req = 4'b0011; nx_num[27:14] = 14'd3333;
        tick(3);
        nx_req = 4'b0010;
        tick(15);
        nx_req = 4'b0001; nx_num[13:0] = 14'd12000;
        tick(6);
        nx_num[13:0] = 14'd42;   tick(3);
        nx_num[13:0] = 14'd9999; tick(2);
        nx_num[13:0] = 14'd10000; tick(2);
        nx_num[13:0] = 14'd16383; tick(2);
        nx_req = 4'b0000;
        tick(6);
        do_reset("reset_mid_blank");
        nx_req = 4'b1111;
        tick(60);
        do_reset("reset_mid_show_b");
        tick(20);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) nx_req = 4'($urandom);
            if ($urandom_range(0, 3) == 0) nx_num[14*$urandom_range(0, N-1) +: 14] = 14'($urandom);
            if ($urandom_range(0, 7) == 0) begin nx_dig = 16'($urandom); nx_dp = 16'($urandom); end
            if (i % 997 == 500) do_reset("reset_random");
            tick(1);
        end
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
